// File: rtl/arm_pkg.sv
// Shared types and constants for the arm motion sequencer.
// Mode, coordinate and FSM state definitions plus home position defaults.
package arm_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE       = 2'd0,
        MODE_KEYBOARD   = 2'd1,
        MODE_ULTRASONIC = 2'd2,
        MODE_XADC       = 2'd3
    } mode_t;

    typedef logic [7:0] coord_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } seq_state_t;

    localparam int HOME_X_DEF = 4;
    localparam int HOME_Y_DEF = 4;

endpackage

// File: rtl/tick_gen.sv
// Free-running update-tick prescaler for the arm motion sequencer.
// Emits a one-cycle tick when the count reaches TICK_DIV-1, then wraps.
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    // Prescaler count, wrapping on each tick.
    always_ff @(posedge clk) begin
        if (reset || tick) cnt <= '0;
        else               cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/arm_motion_sequencer.sv
// Arm motion sequencer: source select, clamp, slew-limited command issue.
// Optional feature macro MOTION_SLEW_EN: stepped motion; otherwise jump to target.
module arm_motion_sequencer
    import arm_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int STEP         = 1,
    parameter int SETTLE_TICKS = 2,
    parameter int X_MAX        = 12,
    parameter int Y_MAX        = 12,
    parameter int HOME_X       = HOME_X_DEF,
    parameter int HOME_Y       = HOME_Y_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [7:0] kb_x,
    input  logic [7:0] kb_y,
    input  logic       kb_valid,
    input  logic [7:0] us_x,
    input  logic [7:0] us_y,
    input  logic       us_valid,
    input  logic [7:0] ad_x,
    input  logic [7:0] ad_y,
    input  logic       ad_valid,
    output logic [7:0] cmd_x,
    output logic [7:0] cmd_y,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       busy,
    output logic [1:0] active_src
);

    localparam coord_t HX   = coord_t'(HOME_X);
    localparam coord_t HY   = coord_t'(HOME_Y);
    localparam coord_t XLIM = coord_t'(X_MAX);
    localparam coord_t YLIM = coord_t'(Y_MAX);
    localparam logic [15:0] SETTLE_LAST =
        16'((SETTLE_TICKS > 0) ? SETTLE_TICKS - 1 : 0);

    seq_state_t  state;
    coord_t      tgt_x, tgt_y;
    coord_t      pos_x, pos_y;
    coord_t      nxt_x, nxt_y;
    coord_t      src_x, src_y;
    logic        src_v;
    logic        mode_chg;
    mode_t       sel;
    logic        tick;
    logic [15:0] settle_cnt;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    function automatic coord_t clamp(coord_t v, coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

`ifdef MOTION_SLEW_EN
    localparam logic signed [8:0] STEP_S = 9'(STEP);
    localparam coord_t            STEP_C = coord_t'(STEP);

    function automatic coord_t step_to(coord_t p, coord_t t);
        logic signed [8:0] d;
        d = $signed({1'b0, t}) - $signed({1'b0, p});
        if (d > STEP_S)       return p + STEP_C;
        else if (d < -STEP_S) return p - STEP_C;
        else                  return t;
    endfunction

    assign nxt_x = step_to(pos_x, tgt_x);
    assign nxt_y = step_to(pos_y, tgt_y);
`else
    assign nxt_x = tgt_x;
    assign nxt_y = tgt_y;
`endif

    assign cmd_x = pos_x;
    assign cmd_y = pos_y;

    // Pick the source feeding the target: new mode on change, else latched.
    always_comb begin
        mode_chg = (mode != active_src);
        sel      = mode_t'(mode_chg ? mode : active_src);
        src_x    = HX;
        src_y    = HY;
        src_v    = 1'b0;
        unique case (sel)
            MODE_KEYBOARD: begin
                src_x = kb_x; src_y = kb_y; src_v = kb_valid;
            end
            MODE_ULTRASONIC: begin
                src_x = us_x; src_y = us_y; src_v = us_valid;
            end
            MODE_XADC: begin
                src_x = ad_x; src_y = ad_y; src_v = ad_valid;
            end
            default: begin
                src_x = HX; src_y = HY; src_v = 1'b0;
            end
        endcase
    end

    // Target latch with clamp on every load.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_src <= 2'd0;
            tgt_x      <= HX;
            tgt_y      <= HY;
        end else if (mode_chg || src_v) begin
            active_src <= mode;
            tgt_x      <= clamp(src_x, XLIM);
            tgt_y      <= clamp(src_y, YLIM);
        end
    end

    // Issue/settle FSM with registered command outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pos_x      <= HX;
            pos_y      <= HY;
            cmd_valid  <= 1'b0;
            busy       <= 1'b0;
            settle_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (tick && (pos_x != tgt_x || pos_y != tgt_y)) begin
                        pos_x     <= nxt_x;
                        pos_y     <= nxt_y;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid  <= 1'b0;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (SETTLE_TICKS == 0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_motion_sequencer.sv
// Directed self-checking bench for arm_motion_sequencer.
// Expectations follow the MOTION_SLEW_EN setting of the build.
module tb_arm_motion_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [7:0] kb_x, kb_y, us_x, us_y, ad_x, ad_y;
    logic       kb_valid, us_valid, ad_valid;
    logic [7:0] cmd_x, cmd_y;
    logic       cmd_valid, cmd_ready, busy;
    logic [1:0] active_src;

    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;
    int hx[$];
    int hy[$];
    int ht[$];

    always #5 clk = ~clk;

    arm_motion_sequencer #(
        .TICK_DIV(4), .STEP(1), .SETTLE_TICKS(1),
        .X_MAX(12), .Y_MAX(12), .HOME_X(4), .HOME_Y(4)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .kb_x(kb_x), .kb_y(kb_y), .kb_valid(kb_valid),
        .us_x(us_x), .us_y(us_y), .us_valid(us_valid),
        .ad_x(ad_x), .ad_y(ad_y), .ad_valid(ad_valid),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .busy(busy), .active_src(active_src)
    );

    // Log every accepted command with its cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && cmd_valid && cmd_ready) begin
            hx.push_back(int'(cmd_x));
            hy.push_back(int'(cmd_y));
            ht.push_back(cyc);
        end
    end

    task automatic clear_log();
        hx.delete(); hy.delete(); ht.delete();
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_log(string nm, int ex[$], int ey[$]);
        total++;
        if (hx.size() !== ex.size())
            $display("FAIL %s count: got %0d want %0d", nm, hx.size(), ex.size());
        else begin
            pass_cnt++;
            foreach (ex[i]) begin
                total++;
                if (hx[i] !== ex[i] || hy[i] !== ey[i])
                    $display("FAIL %s cmd%0d: got (%0d,%0d) want (%0d,%0d)",
                             nm, i, hx[i], hy[i], ex[i], ey[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1; mode = 2'd0; cmd_ready = 1'b0;
        kb_x = 0; kb_y = 0; us_x = 0; us_y = 0; ad_x = 0; ad_y = 0;
        kb_valid = 0; us_valid = 0; ad_valid = 0;
        cycles(3);
        total++;
        if (cmd_x !== 8'd4 || cmd_y !== 8'd4 || cmd_valid !== 1'b0 ||
            busy !== 1'b0 || active_src !== 2'd0)
            $display("FAIL reset_state: got cmd=(%0d,%0d) v=%b busy=%b src=%0d want (4,4) 0 0 0",
                     cmd_x, cmd_y, cmd_valid, busy, active_src);
        else pass_cnt++;
        reset = 1'b0;
        cmd_ready = 1'b1;
        clear_log();
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_valid) seen++;
        end
        total++;
        if (seen !== 0 || hx.size() !== 0)
            $display("FAIL idle_quiet: got %0d valid cycles want 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_keyboard();
        int ex[$];
        int ey[$];
        int bad;
`ifdef MOTION_SLEW_EN
        ex = '{5, 6, 7}; ey = '{5, 6, 6};
`else
        ex = '{7}; ey = '{6};
`endif
        clear_log();
        mode = 2'd1; kb_x = 7; kb_y = 6; kb_valid = 1'b1;
        cycles(1);
        kb_valid = 1'b0;
        cycles(100);
        check_log("kb_seq", ex, ey);
        bad = 0;
        for (int i = 1; i < ht.size(); i++)
            if (ht[i] - ht[i-1] < 8) bad++;
        total++;
        if (bad !== 0) $display("FAIL kb_spacing: got %0d close pairs want 0", bad);
        else pass_cnt++;
        total++;
        if (busy !== 1'b0 || active_src !== 2'd1)
            $display("FAIL kb_done: got busy=%b src=%0d want 0 1", busy, active_src);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int ex[$];
        int ey[$];
        int n;
        int bad;
        logic [7:0] sx, sy;
`ifdef MOTION_SLEW_EN
        ex = '{6, 7, 8, 9}; ey = '{6, 5, 4, 4};
`else
        ex = '{3, 9}; ey = '{6, 4};
`endif
        clear_log();
        cmd_ready = 1'b0;
        kb_x = 3; kb_y = 6; kb_valid = 1'b1;
        cycles(1);
        kb_valid = 1'b0;
        n = 0;
        while (!cmd_valid && n < 50) begin cycles(1); n++; end
        total++;
        if (!cmd_valid) $display("FAIL stall_wait: got valid=0 want 1 within 50 cycles");
        else pass_cnt++;
        sx = cmd_x; sy = cmd_y;
        total++;
        if (int'(sx) !== ex[0] || int'(sy) !== ey[0])
            $display("FAIL stall_cmd: got (%0d,%0d) want (%0d,%0d)", sx, sy, ex[0], ey[0]);
        else pass_cnt++;
        mode = 2'd2; us_x = 9; us_y = 4;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (!cmd_valid || cmd_x !== sx || cmd_y !== sy) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        else pass_cnt++;
        total++;
        if (active_src !== 2'd2) $display("FAIL stall_src: got %0d want 2", active_src);
        else pass_cnt++;
        cmd_ready = 1'b1;
        cycles(150);
        check_log("stall_seq", ex, ey);
    endtask

    task automatic test_clamp();
        int ex[$];
        int ey[$];
        int over;
`ifdef MOTION_SLEW_EN
        ex = '{10, 11, 12, 12, 12, 12, 12, 12};
        ey = '{5, 6, 7, 8, 9, 10, 11, 12};
`else
        ex = '{12}; ey = '{12};
`endif
        clear_log();
        us_x = 200; us_y = 255; us_valid = 1'b1;
        cycles(1);
        us_valid = 1'b0;
        cycles(200);
        check_log("clamp_seq", ex, ey);
        over = 0;
        foreach (hx[i]) if (hx[i] > 12 || hy[i] > 12) over++;
        total++;
        if (over !== 0) $display("FAIL clamp_limit: got %0d over-range cmds want 0", over);
        else pass_cnt++;
    endtask

    task automatic test_ignore();
        int ex[$];
        int ey[$];
        int none[$];
`ifdef MOTION_SLEW_EN
        ex = '{11, 10, 9, 8, 7, 6, 5, 4};
        ey = '{11, 10, 9, 8, 7, 6, 5, 4};
`else
        ex = '{4}; ey = '{4};
`endif
        clear_log();
        ad_x = 12; ad_y = 12; mode = 2'd3;
        cycles(2);
        kb_x = 1; kb_y = 1; kb_valid = 1'b1;
        cycles(1);
        kb_valid = 1'b0;
        cycles(40);
        check_log("ignore_kb", none, none);
        total++;
        if (active_src !== 2'd3) $display("FAIL ignore_src: got %0d want 3", active_src);
        else pass_cnt++;
        clear_log();
        mode = 2'd0;
        cycles(200);
        check_log("park_seq", ex, ey);
    endtask

    task automatic test_single();
        int ex[$];
        int ey[$];
`ifdef MOTION_SLEW_EN
        ex = '{5, 6, 7, 8, 9, 10}; ey = '{3, 2, 2, 2, 2, 2};
`else
        ex = '{10}; ey = '{2};
`endif
        clear_log();
        kb_x = 10; kb_y = 2; mode = 2'd1;
        cycles(120);
        check_log("single_seq", ex, ey);
    endtask

    task automatic test_reset_mid();
        int n;
        int early;
        cmd_ready = 1'b0;
        kb_x = 4; kb_y = 8; kb_valid = 1'b1;
        cycles(1);
        kb_valid = 1'b0;
        n = 0;
        while (!cmd_valid && n < 50) begin cycles(1); n++; end
        total++;
        if (!cmd_valid) $display("FAIL rst_mid_wait: got valid=0 want 1 within 50 cycles");
        else pass_cnt++;
        reset = 1'b1;
        cycles(1);
        total++;
        if (cmd_valid !== 1'b0 || cmd_x !== 8'd4 || cmd_y !== 8'd4 || busy !== 1'b0)
            $display("FAIL rst_mid: got v=%b cmd=(%0d,%0d) busy=%b want 0 (4,4) 0",
                     cmd_valid, cmd_x, cmd_y, busy);
        else pass_cnt++;
        reset = 1'b0;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            if (cmd_valid) early++;
        end
        total++;
        if (early !== 0) $display("FAIL rst_no_early: got %0d valid cycles want 0", early);
        else pass_cnt++;
        cycles(2);
        total++;
        if (cmd_valid !== 1'b1 || active_src !== 2'd1)
            $display("FAIL rst_resume: got v=%b src=%0d want 1 1", cmd_valid, active_src);
        else pass_cnt++;
        cmd_ready = 1'b1;
        mode = 2'd0;
        cycles(10);
    endtask

    initial begin
        test_reset();
        test_keyboard();
        test_stall();
        test_clamp();
        test_ignore();
        test_single();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/arm_motion_sequencer.md
# arm_motion_sequencer

Sequences arm motion between the coordinate sources and the servo/inverse-kinematics datapath.
- Selects the active (x,y) target source (keyboard, ultrasonic or XADC) from the mode FSM state.
- Clamps the target to the reachable range and slew-limits motion, once per update tick, in bounded steps.
- Issues each intermediate position downstream over a valid/ready handshake, then waits a settle period.
- Sits between the coordinate producers and the servo-drive logic inside the FSM controller.

## Interface
- TICK_DIV, 100000: clk cycles per update tick (100 Hz at 10 MHz).
- STEP, 1: max per-axis change per command, inches.
- SETTLE_TICKS, 2: ticks to wait after each accepted command.
- X_MAX, 12: target x clamp. Y_MAX, 12: target y clamp.
- HOME_X, 4: park x. HOME_Y, 4: park y.

- clk  in  1  10 MHz system clock
- reset  in  1  synchronous, active-high
- mode  in  2  mode_t: 0 IDLE/park, 1 KEYBOARD, 2 ULTRASONIC, 3 XADC
- kb_x, kb_y  in  8  keyboard coordinates; kb_valid  in  1  update strobe
- us_x, us_y  in  8  ultrasonic coordinates; us_valid  in  1
- ad_x, ad_y  in  8  XADC coordinates; ad_valid  in  1
- cmd_x, cmd_y  out  8  commanded position
- cmd_valid  out  1  command pending
- cmd_ready  in  1  downstream accepts
- busy  out  1  high whenever the sequencer is not in S_IDLE
- active_src  out  2  currently latched mode

## Operation
- Registers:
  - tgt_x, tgt_y: target.
  - pos_x, pos_y: last issued position; cmd_x/cmd_y are driven directly from pos.
  - active_src.
- Target latch:
  - A mode change loads tgt from the newly selected source's current x/y. Mode 0 loads HOME_X/HOME_Y.
  - The selected source's valid strobe reloads tgt. Strobes from non-selected sources are ignored.
  - Clamp on load: value > X_MAX becomes X_MAX, value > Y_MAX becomes Y_MAX. Inputs are unsigned.
  - A mode change and a strobe in the same cycle: the new mode's source is loaded.
- FSM states: S_IDLE, S_ISSUE, S_SETTLE.
  - S_IDLE: on tick with pos != tgt, compute next pos per axis and go to S_ISSUE. Otherwise stay.
  - Next-pos arithmetic: axis moves toward tgt by min(STEP, |tgt-pos|). Axes are independent. Compute in 9-bit signed; the result never overshoots tgt and never leaves 0..255.
  - S_ISSUE: cmd_valid=1. On cmd_valid && cmd_ready, go to S_SETTLE with the settle counter at 0.
  - S_SETTLE: count ticks; after SETTLE_TICKS ticks, return to S_IDLE.
- Target changes during S_ISSUE/S_SETTLE update tgt only. The in-flight command is never altered.
- Outputs at reset:
  - pos = tgt = (HOME_X, HOME_Y), so cmd = home.
  - cmd_valid=0, busy=0, active_src=0, FSM in S_IDLE, tick counter 0.

## Timing
- Tick: single-cycle pulse when the prescaler equals TICK_DIV-1; the counter then wraps to 0. Free-running, never gated by the FSM.
- Strobe or mode change to tgt updated: 1 cycle.
- Tick in S_IDLE to cmd_valid high with new cmd_x/cmd_y: 1 cycle (registered).
- cmd_valid, once high, stays high with cmd_x/cmd_y stable until the handshake cycle. It drops the following cycle.
- Minimum spacing between commands: SETTLE_TICKS+1 ticks.
- cmd_ready may be held low indefinitely: no timeout, no drop of valid.
- Reset mid-handshake: cmd_valid low at the next edge and pos returns to home. No further command is issued until the next tick.
- SETTLE_TICKS=0: S_SETTLE exits on its first cycle.

## Configuration
- MOTION_SLEW_EN defined: stepped motion as above.
- MOTION_SLEW_EN undefined:
  - Next pos = tgt directly, so one command per target change.
  - STEP is unused. Tick gating and settle still apply.

## Structure
- Package arm_pkg holds:
  - mode_t enum (IDLE, KEYBOARD, ULTRASONIC, XADC).
  - coord_t (logic [7:0]).
  - seq_state_t enum.
  - HOME_X/HOME_Y default constants.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick) implements the prescaler.
- Clamp and step arithmetic stay in arm_motion_sequencer.

## Test plan
All tests use TICK_DIV=4, STEP=1, SETTLE_TICKS=1, MOTION_SLEW_EN defined unless stated.
- Reset held 3 cycles -> cmd=(4,4), cmd_valid=0, busy=0, active_src=0, and no command for 50 cycles with mode=0.
- mode=1, kb=(7,6) with kb_valid pulse, cmd_ready=1 -> commands (5,5), (6,6), (7,6) in order, each at least 2 ticks apart, then busy=0.
- cmd_ready=0 for 20 cycles in S_ISSUE, and mode switched to 2 meanwhile with us=(9,4) -> cmd_valid stays 1 and cmd is unchanged. After ready, the sequencer continues toward (9,4).
- mode=2, us=(200,255) -> tgt=(12,12); final command (12,12), never exceeded.
- kb_valid on kb=(1,1) while mode=3 -> ignored. Mode set to 0 -> sequencer steps back to (4,4).
- MOTION_SLEW_EN undefined, mode=1, kb=(10,2) -> exactly one command (10,2). Reset asserted mid-handshake -> cmd_valid=0 next cycle, cmd=(4,4).
